// File: rtl/solitaire_pkg.sv
// Shared definitions for the solitaire pile datapath.
// Holds the card layout, suit/op/error/mode codes and the pile engine FSM states.
// No ports: imported by card_legal and card_pile_engine.
package solitaire_pkg;

  // Card layout: [6:3] rank 1..13, [2:1] suit, [0] face-up.
  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
    logic       face_up;
  } card_t;

  localparam logic [1:0] SuitHearts   = 2'b00;
  localparam logic [1:0] SuitClubs    = 2'b01;
  localparam logic [1:0] SuitDiamonds = 2'b10;
  localparam logic [1:0] SuitSpades   = 2'b11;

  localparam logic [3:0] RankAce  = 4'd1;
  localparam logic [3:0] RankKing = 4'd13;

  typedef enum logic [1:0] {
    OpPush  = 2'd0,
    OpPop   = 2'd1,
    OpFlip  = 2'd2,
    OpClear = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrBound    = 2'd1,  // overflow / underflow / zero count / empty flip
    ErrIllegal  = 2'd2,  // card breaks the pile's placement rule
    ErrFaceDown = 2'd3   // face-down card inside a popped run
  } err_e;

  localparam int unsigned ModeTableau    = 0;
  localparam int unsigned ModeFoundation = 1;
  localparam int unsigned ModeUnchecked  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPush = 2'd1,
    StPop  = 2'd2,
    StFin  = 2'd3
  } state_e;

  function automatic logic is_red(input logic [1:0] suit);
    logic red;
    red = 1'b0;
    case (suit)
      SuitHearts, SuitDiamonds: red = 1'b1;
      SuitClubs, SuitSpades:    red = 1'b0;
      default:                  red = 1'b0;
    endcase
    return red;
  endfunction

endpackage

// File: rtl/card_legal.sv
// Combinational placement check for one incoming card against the pile top.
// Parameters: MODE (0 tableau, 1 foundation, 2 unchecked).
// Ports:
//   empty_i  pile currently holds no cards
//   top_i    current top card (ignored when empty)
//   card_i   incoming card
//   legal_o  card may be placed on this pile
// The foundation single-card restriction is a command property and is checked by the caller.
module card_legal
  import solitaire_pkg::*;
#(
  parameter int unsigned MODE = ModeTableau
) (
  input  logic  empty_i,
  input  card_t top_i,
  input  card_t card_i,
  output logic  legal_o
);

  always_comb begin
    legal_o = 1'b0;
    if (MODE == ModeUnchecked) begin
      legal_o = 1'b1;
    end else if (card_i.face_up) begin
      if (MODE == ModeTableau) begin
        if (empty_i) begin
          legal_o = (card_i.rank == RankKing);
        end else begin
          // Rank 0 is never a real card; exclude it so an ace top cannot accept it.
          legal_o = (card_i.rank != 4'd0) && (card_i.rank == top_i.rank - 4'd1) &&
                    (is_red(card_i.suit) != is_red(top_i.suit));
        end
      end else begin
        if (empty_i) begin
          legal_o = (card_i.rank == RankAce);
        end else begin
          legal_o = (card_i.suit == top_i.suit) && (card_i.rank == top_i.rank + 4'd1);
        end
      end
    end
  end

endmodule

// File: rtl/card_pile_engine.sv
// Single solitaire pile: storage plus a command-driven stream transfer engine.
// Parameters: DEPTH (max cards), CARD_W (card width, layout fixed at 7 bits),
//             MODE (0 tableau, 1 foundation, 2 unchecked stock/talon).
// Optional build macro PILE_AUTOFLIP_EN: in tableau mode, a successful POP that leaves a
// face-down top turns that card face-up in time for the done pulse.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/ready       command handshake (ready only in IDLE)
//   cmd_op, cmd_count     0 PUSH, 1 POP, 2 FLIP, 3 CLEAR; run length for PUSH/POP
//   in_valid/ready/card   push stream
//   out_valid/ready/card  pop stream (deepest card of the run first)
//   top_card, pile_count  current top (0 when empty) and number of cards held
//   done, err             one-cycle completion / rejection pulses
//   err_code              last error code, held until the next accepted command
module card_pile_engine
  import solitaire_pkg::*;
#(
  parameter int unsigned DEPTH  = 19,
  parameter int unsigned CARD_W = 7,
  parameter int unsigned MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [$clog2(DEPTH+1)-1:0] cmd_count,
  input  logic                       in_valid,
  input  logic [CARD_W-1:0]          in_card,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [CARD_W-1:0]          out_card,
  input  logic                       out_ready,
  output logic [CARD_W-1:0]          top_card,
  output logic [$clog2(DEPTH+1)-1:0] pile_count,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  state_e              state_q, state_d;
  logic [CARD_W-1:0]   mem_q [DEPTH];
  logic [CntW-1:0]     pile_count_q, pile_count_d;
  logic [CntW-1:0]     remain_q, remain_d;
  logic [CntW-1:0]     base_q, base_d;      // PUSH: count to restore; POP: first index
  logic [CntW-1:0]     pop_idx_q, pop_idx_d;
  logic                done_q, done_d, err_q, err_d;
  err_e                err_code_q, err_code_d;

  logic                wr_en;
  logic [IdxW-1:0]     wr_idx;
  logic [CARD_W-1:0]   wr_data;

  op_e                 op;
  logic                accept, empty, in_legal, any_down;
  logic [CntW:0]       push_sum;
  logic [CntW-1:0]     run_lo;
  logic [CARD_W-1:0]   top_card_c;
  err_e                cmd_err;

  assign op         = op_e'(cmd_op);
  assign accept     = cmd_valid && (state_q == StIdle);
  assign empty      = (pile_count_q == '0);
  assign top_card_c = empty ? '0 : mem_q[IdxW'(pile_count_q - 1'b1)];
  assign push_sum   = {1'b0, pile_count_q} + {1'b0, cmd_count};

  card_legal #(
    .MODE (MODE)
  ) u_card_legal (
    .empty_i (empty),
    .top_i   (card_t'(top_card_c[6:0])),
    .card_i  (card_t'(in_card[6:0])),
    .legal_o (in_legal)
  );

  // Scan the top cmd_count entries for face-down cards.
  always_comb begin
    any_down = 1'b0;
    run_lo   = pile_count_q - cmd_count;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CntW'(i) >= run_lo && CntW'(i) < pile_count_q && !mem_q[i][0]) begin
        any_down = 1'b1;
      end
    end
  end

  always_comb begin
    cmd_err = ErrNone;
    unique case (op)
      OpPush: begin
        if (cmd_count == '0 || push_sum > (CntW + 1)'(DEPTH)) begin
          cmd_err = ErrBound;
        end else if (MODE == ModeFoundation && cmd_count != CntW'(1)) begin
          cmd_err = ErrIllegal;
        end
      end
      OpPop: begin
        if (cmd_count == '0 || cmd_count > pile_count_q) begin
          cmd_err = ErrBound;
        end else if (MODE != ModeUnchecked && any_down) begin
          cmd_err = ErrFaceDown;
        end
      end
      OpFlip:  if (empty) cmd_err = ErrBound;
      OpClear: cmd_err = ErrNone;
      default: cmd_err = ErrNone;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && cmd_err == ErrNone) begin
          if (op == OpPush) begin
            state_d = StPush;
          end else if (op == OpPop) begin
            state_d = StPop;
          end
        end
      end
      StPush: begin
        if (in_valid) begin
          if (!in_legal) begin
            state_d = StIdle;
          end else if (remain_q == CntW'(1)) begin
            state_d = StFin;
          end
        end
      end
      StPop:   if (out_ready && remain_q == CntW'(1)) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready  = (state_q == StIdle);
    in_ready   = (state_q == StPush);
    out_valid  = (state_q == StPop);
    out_card   = out_valid ? mem_q[IdxW'(pop_idx_q)] : '0;
    top_card   = top_card_c;
    pile_count = pile_count_q;
    done       = done_q;
    err        = err_q;
    err_code   = err_code_q;
  end

  // Datapath next state
  always_comb begin
    pile_count_d = pile_count_q;
    remain_d     = remain_q;
    base_d       = base_q;
    pop_idx_d    = pop_idx_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    wr_en        = 1'b0;
    wr_idx       = IdxW'(pile_count_q);
    wr_data      = in_card;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_code_d = cmd_err;
          if (cmd_err != ErrNone) begin
            err_d = 1'b1;
          end else begin
            unique case (op)
              OpPush: begin
                base_d   = pile_count_q;
                remain_d = cmd_count;
              end
              OpPop: begin
                base_d    = run_lo;
                pop_idx_d = run_lo;
                remain_d  = cmd_count;
              end
              OpFlip: begin
                wr_en   = 1'b1;
                wr_idx  = IdxW'(pile_count_q - 1'b1);
                wr_data = {top_card_c[CARD_W-1:1], 1'b1};
                done_d  = 1'b1;
              end
              OpClear: begin
                pile_count_d = '0;
                done_d       = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      StPush: begin
        if (in_valid) begin
          if (in_legal) begin
            wr_en        = 1'b1;
            pile_count_d = pile_count_q + 1'b1;
            remain_d     = remain_q - 1'b1;
            done_d       = (remain_q == CntW'(1));
          end else begin
            // Roll back the partial run; cards already written sit above the count.
            pile_count_d = base_q;
            err_d        = 1'b1;
            err_code_d   = ErrIllegal;
          end
        end
      end
      StPop: begin
        if (out_ready) begin
          pop_idx_d = pop_idx_q + 1'b1;
          remain_d  = remain_q - 1'b1;
          if (remain_q == CntW'(1)) begin
            pile_count_d = base_q;
            done_d       = 1'b1;
`ifdef PILE_AUTOFLIP_EN
            // Written on the final beat so the new top is face-up while done is high.
            if (MODE == ModeTableau && base_q != '0) begin
              wr_en   = 1'b1;
              wr_idx  = IdxW'(base_q - 1'b1);
              wr_data = {mem_q[IdxW'(base_q - 1'b1)][CARD_W-1:1], 1'b1};
            end
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pile_count_q <= '0;
      remain_q     <= '0;
      base_q       <= '0;
      pop_idx_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ErrNone;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pile_count_q <= pile_count_d;
      remain_q     <= remain_d;
      base_q       <= base_d;
      pop_idx_q    <= pop_idx_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      if (wr_en) begin
        mem_q[wr_idx] <= wr_data;
      end
    end
  end

endmodule
